// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass and pending-write scoreboard
module regfile_mp #(
    parameter int              XLEN   = 32,
    parameter int              NREGS  = 32,
    parameter int              AW     = 5,
    parameter int              NRD    = 2,
    parameter int              SP_IDX = 2,
    parameter logic [XLEN-1:0] SP_RST = 32'hFFFFFFFF,
    parameter bit              BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 iss_vld,
    input  logic [AW-1:0]        iss_addr,
    output logic [AW:0]          busy_cnt
);
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy, busy_nxt;
    logic [AW:0] cnt_nxt;

    // an issue and a writeback to the same register leave it busy: the issue is the newer producer
    always_comb begin
        busy_nxt = '0;
        cnt_nxt = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_nxt[r] = (iss_vld && iss_addr == AW'(r)) || (busy[r] && !(wb_we && wb_addr == AW'(r)));
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign regs[r] = '0;
        end else begin : g_live
            logic [XLEN-1:0] q;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    q <= (r == SP_IDX) ? SP_RST : '0;
                else if (wb_we && wb_addr == AW'(r))
                    q <= wb_data;
            end
            assign regs[r] = q;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          byp;
        assign addr = rd_addr[i*AW +: AW];
        assign byp = BYPASS && wb_we && wb_addr == addr;
        assign rd_data[i*XLEN +: XLEN] = (addr == '0) ? '0 : byp ? wb_data : regs[addr];
        assign rd_busy[i] = busy[addr] && addr != '0 && !byp;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized check of regfile_mp (bypass and no-bypass builds) against an array model
module tb_regfile_mp;
    localparam int XLEN = 32, NREGS = 32, AW = 5, NRD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]      rd_busy, rd_busy_nb;
    logic                wb_we, iss_vld;
    logic [AW-1:0]       wb_addr, iss_addr;
    logic [XLEN-1:0]     wb_data;
    logic [AW:0]         busy_cnt, busy_cnt_nb;

    int n_cmp = 0, n_bad = 0;
    logic [XLEN-1:0] m_reg [NREGS];
    bit m_busy [NREGS];

    regfile_mp #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .iss_vld(iss_vld),
        .iss_addr(iss_addr), .busy_cnt(busy_cnt));

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .iss_vld(iss_vld),
        .iss_addr(iss_addr), .busy_cnt(busy_cnt_nb));

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] m_rd(int a, bit byp);
        if (a == 0) return '0;
        if (byp && wb_we && int'(wb_addr) == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit m_bsy(int a, bit byp);
        return a != 0 && m_busy[a] && !(byp && wb_we && int'(wb_addr) == a);
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    // writeback clears before issue sets, so a same-register collision ends busy
    task automatic model_update();
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                m_reg[r] = (r == 2) ? 32'hFFFFFFFF : '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wb_we && wb_addr != 0) m_reg[wb_addr] = wb_data;
            if (wb_we) m_busy[wb_addr] = 1'b0;
            if (iss_vld && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        int a;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            check($sformatf("rd_data[%0d] a=%0d", i, a), rd_data[i*XLEN +: XLEN], m_rd(a, 1'b1));
            check($sformatf("rd_busy[%0d] a=%0d", i, a), rd_busy[i], m_bsy(a, 1'b1));
            check($sformatf("nb rd_data[%0d] a=%0d", i, a), rd_data_nb[i*XLEN +: XLEN], m_rd(a, 1'b0));
            check($sformatf("nb rd_busy[%0d] a=%0d", i, a), rd_busy_nb[i], m_bsy(a, 1'b0));
        end
        check("busy_cnt", busy_cnt, 64'(m_cnt()));
        check("nb busy_cnt", busy_cnt_nb, 64'(m_cnt()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rd_addr = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        iss_vld = 1'b0; iss_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        rd_addr = {5'd5, 5'd2};
        #1;
        check("rst sp", rd_data[31:0], 32'hFFFFFFFF);
        check("rst r5", rd_data[63:32], 32'h0);
        check("rst busy", rd_busy, 2'b00);
        check("rst cnt", busy_cnt, 6'd0);
        cycle();
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
        cycle();
        wb_we = 1'b0; rd_addr = {5'd0, 5'd0};
        #1;
        check("r0 write", rd_data[31:0], 32'h0);
        cycle();
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678; rd_addr = {5'd7, 5'd7};
        #1;
        check("bypass same cycle", rd_data[63:32], 32'h12345678);
        check("nobypass old", rd_data_nb[63:32], 32'h0);
        cycle();
        wb_we = 1'b0;
        #1;
        check("nobypass next", rd_data_nb[63:32], 32'h12345678);
        cycle();
        iss_vld = 1'b1; iss_addr = 5'd9;
        cycle();
        iss_vld = 1'b0; rd_addr = {5'd9, 5'd9};
        #1;
        check("busy r9", rd_busy[0], 1'b1);
        check("cnt one", busy_cnt, 6'd1);
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5;
        #1;
        check("wb masks busy", rd_busy[0], 1'b0);
        check("nb keeps busy", rd_busy_nb[0], 1'b1);
        cycle();
        wb_we = 1'b0;
        #1;
        check("cnt cleared", busy_cnt, 6'd0);
        cycle();
        iss_vld = 1'b1; iss_addr = 5'd4;
        cycle();
        wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        cycle();
        iss_vld = 1'b0; wb_we = 1'b0; rd_addr = {5'd4, 5'd4};
        #1;
        check("set wins busy", rd_busy[1], 1'b1);
        check("set wins cnt", busy_cnt, 6'd1);
        check("set wins data", rd_data[63:32], 32'h44);
        cycle();
        iss_vld = 1'b1;
        for (int a = 3; a <= 5; a++) begin
            iss_addr = AW'(a);
            cycle();
        end
        iss_vld = 1'b0;
        #1;
        check("three busy", busy_cnt, 6'd3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1; rd_addr = {5'd4, 5'd2};
        #1;
        check("mid rst cnt", busy_cnt, 6'd0);
        check("mid rst busy", rd_busy, 2'b00);
        check("mid rst sp", rd_data[31:0], 32'hFFFFFFFF);
        check("mid rst r4", rd_data[63:32], 32'h0);
        cycle();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            wb_we = $urandom_range(0, 1) != 0;
            wb_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wb_data = $urandom;
            iss_vld = $urandom_range(0, 2) != 0;
            iss_addr = ($urandom_range(0, 3) == 0) ? wb_addr : AW'($urandom);
            rd_addr[0 +: AW] = ($urandom_range(0, 2) == 0) ? wb_addr : AW'($urandom);
            rd_addr[AW +: AW] = ($urandom_range(0, 3) == 0) ? rd_addr[0 +: AW] : AW'($urandom);
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's integer register file.
- Provides NRD combinational read ports, one synchronous write port, optional write-to-read bypass, and a per-register pending-write scoreboard.
- Sits between decode/issue (read ports and issue marking) and writeback (write port and busy clear).
- Lets the pipeline detect RAW hazards without a separate scoreboard block.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, minimum 4.
- AW, 5, address width; must equal log2(NREGS).
- NRD, 2, number of read ports, 1..4.
- SP_IDX, 2, index of the stack-pointer register that gets a non-zero reset value.
- SP_RST, 32'hFFFFFFFF, reset value of register SP_IDX (XLEN bits).
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to matching read ports; 0 = no forwarding.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, reset, synchronous, active-low.
- rd_addr, in, NRD*AW, read addresses; port i is bits [i*AW +: AW].
- rd_data, out, NRD*XLEN, read data; port i is bits [i*XLEN +: XLEN].
- rd_busy, out, NRD, port i's source register has an outstanding write.
- wb_we, in, 1, writeback write enable.
- wb_addr, in, AW, writeback destination.
- wb_data, in, XLEN, writeback data.
- iss_vld, in, 1, an instruction is issued this cycle with destination iss_addr.
- iss_addr, in, AW, issued instruction's destination register.
- busy_cnt, out, AW+1, registered count of registers currently marked busy.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All registers are 0, except reg[SP_IDX] = SP_RST.
  - busy[] all 0; busy_cnt = 0.
  - wb_we and iss_vld are ignored in a reset cycle.
  - Reset asserted mid-operation discards all pending busy marks.
- Register 0:
  - Always reads 0 and is never written; wb_we with wb_addr=0 is a no-op.
  - Never marked busy; iss_vld with iss_addr=0 is a no-op.
- Write: on posedge clk with rst_n=1 and wb_we=1, reg[wb_addr] <= wb_data. Latency 1 cycle when BYPASS=0.
- Read (combinational, per port i, addr = rd_addr port i):
  - addr==0 -> 0.
  - else BYPASS=1 and wb_we and wb_addr==addr -> wb_data.
  - else reg[addr].
- Busy output, per port i:
  - rd_busy[i] = busy[addr] & (addr!=0).
  - When BYPASS=1, additionally mask with ~(wb_we & wb_addr==addr), so a value being written back this cycle is not reported busy.
- Scoreboard update, per register r≠0 at posedge clk:
  - Set when iss_vld & iss_addr==r.
  - Clear when wb_we & wb_addr==r.
  - Set and clear in the same cycle on the same r: the set wins (a newer producer is in flight).
  - Set on an already-busy register: stays 1.
  - Clear on a non-busy register: no-op.
- busy_cnt: registered, equal to the population count of busy[] after the update; saturation is unnecessary because max = NREGS-1.
- Multiple read ports addressing the same register must return identical data and busy.
- Out-of-range addresses cannot occur, since NREGS = 2^AW.

Test Plan:
- Reset, then read ports 0/1 at addr 2/5 -> rd_data 0xFFFFFFFF / 0x00000000; rd_busy=00; busy_cnt=0.
- wb_we=1, wb_addr=0, wb_data=0xDEADBEEF; next cycle read addr 0 -> 0x00000000.
- BYPASS=1: cycle N wb_we addr 7 data 0x12345678 while rd_addr port1=7 -> same-cycle rd_data 0x12345678; BYPASS=0 -> old value in cycle N, 0x12345678 in N+1.
- iss_vld addr 9 -> next cycle rd_busy=1 for port reading 9, busy_cnt=1; wb_we addr 9 -> rd_busy 0 in that cycle (BYPASS=1), busy_cnt=0 next cycle.
- Same cycle: iss_vld addr 4 and wb_we addr 4 with reg 4 busy -> reg 4 stays busy, busy_cnt unchanged, reg[4] updated.
- Issue addrs 3,4,5 over 3 cycles, assert rst_n=0 for one cycle -> busy_cnt=0, all rd_busy=0, reg[2]=0xFFFFFFFF, reg[3..5]=0.
